// File: rtl/video_level_expander.sv
// Multi-channel colour-level expander: NCH codes of IN_W bits -> OUT_W-bit levels via shared LUT, bit-replicate or zero-pad.
// Latency: 1 clock from pix_valid to lvl_valid; cpu_rdata is 1 clock after cpu_addr.
// Backpressure: none; pixels and CPU accesses are ignored while busy (LUT self-init after reset).
// Ports: clk/rst (sync, active-high); mode, pix_valid, pix_blank, pix_in -> lvl_valid, lvl_out;
//        cpu_we, cpu_addr, cpu_wdata -> cpu_rdata (LUT access); busy high during LUT init.
module video_level_expander #(
    parameter int NCH      = 3,
    parameter int IN_W     = 5,
    parameter int OUT_W    = 8,
    parameter int MAX_CODE = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic                   pix_valid,
    input  logic                   pix_blank,
    input  logic [NCH*IN_W-1:0]    pix_in,
    output logic                   lvl_valid,
    output logic [NCH*OUT_W-1:0]   lvl_out,
    input  logic                   cpu_we,
    input  logic [IN_W-1:0]        cpu_addr,
    input  logic [OUT_W-1:0]       cpu_wdata,
    output logic [OUT_W-1:0]       cpu_rdata,
    output logic                   busy
);
    localparam int DEPTH   = 2**IN_W;
    localparam int OUT_MAX = 2**OUT_W - 1;
    // q grows to roughly (DEPTH-1)*OUT_MAX/MAX_CODE before saturation kicks in,
    // so size it for the full index range rather than just OUT_MAX+MAX_CODE.
    localparam int ACC_W   = OUT_W + IN_W + 1;

    localparam logic [ACC_W-1:0] Q_STEP = ACC_W'(OUT_MAX / MAX_CODE);
    localparam logic [ACC_W-1:0] R_STEP = ACC_W'(OUT_MAX % MAX_CODE);
    localparam logic [ACC_W-1:0] MAXC   = ACC_W'(MAX_CODE);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state_q, state_d;
    logic [IN_W-1:0]        idx_q, idx_d;
    logic [ACC_W-1:0]       q_q, q_d;
    logic [ACC_W-1:0]       r_q, r_d;
    logic                   busy_q, busy_d;
    logic                   lvl_valid_q, lvl_valid_d;
    logic [NCH*OUT_W-1:0]   lvl_out_q, lvl_out_d;
    logic [OUT_W-1:0]       cpu_rdata_q, cpu_rdata_d;

    logic [OUT_W-1:0]       lut_q [DEPTH];
    logic                   lut_we;
    logic [IN_W-1:0]        lut_waddr;
    logic [OUT_W-1:0]       lut_wdata;
    logic [ACC_W-1:0]       r_sum;
    logic [NCH*OUT_W-1:0]   levels;

    // Code repeated MSB-first until the output word is full.
    function automatic logic [OUT_W-1:0] replicate(input logic [IN_W-1:0] c);
        logic [OUT_W-1:0] o;
        o = '0;
        for (int j = 0; j < OUT_W; j++) begin
            o[OUT_W-1-j] = c[IN_W-1-(j % IN_W)];
        end
        return o;
    endfunction

    // Code left-aligned; low bits zero, or code truncated to its top bits.
    function automatic logic [OUT_W-1:0] zero_pad(input logic [IN_W-1:0] c);
        logic [OUT_W-1:0] o;
        o = '0;
        for (int j = 0; j < OUT_W; j++) begin
            if (j < IN_W) begin
                o[OUT_W-1-j] = c[(j < IN_W) ? (IN_W-1-j) : 0];
            end
        end
        return o;
    endfunction

    // Per-channel level selection; all channels read the LUT concurrently.
    always_comb begin
        levels = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!pix_blank) begin
                case (mode)
                    2'd0:    levels[k*OUT_W +: OUT_W] = lut_q[pix_in[k*IN_W +: IN_W]];
                    2'd1:    levels[k*OUT_W +: OUT_W] = replicate(pix_in[k*IN_W +: IN_W]);
                    2'd2:    levels[k*OUT_W +: OUT_W] = zero_pad(pix_in[k*IN_W +: IN_W]);
                    default: levels[k*OUT_W +: OUT_W] = '0;
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        q_d         = q_q;
        r_d         = r_q;
        busy_d      = busy_q;
        lvl_valid_d = 1'b0;
        lvl_out_d   = '0;
        cpu_rdata_d = '0;
        lut_we      = 1'b0;
        lut_waddr   = cpu_addr;
        lut_wdata   = cpu_wdata;
        r_sum       = r_q + R_STEP;

        case (state_q)
            ST_INIT: begin
                // Linear ramp by exact division: q/r track i*OUT_MAX/MAX_CODE.
                lut_we    = 1'b1;
                lut_waddr = idx_q;
                lut_wdata = (idx_q >= IN_W'(MAX_CODE)) ? OUT_W'(OUT_MAX) : q_q[OUT_W-1:0];
                if (r_sum >= MAXC) begin
                    r_d = r_sum - MAXC;
                    q_d = q_q + Q_STEP + ACC_W'(1);
                end else begin
                    r_d = r_sum;
                    q_d = q_q + Q_STEP;
                end
                idx_d = idx_q + IN_W'(1);
                if (idx_q == {IN_W{1'b1}}) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                lut_we      = cpu_we;
                lvl_valid_d = pix_valid;
                lvl_out_d   = pix_valid ? levels : lvl_out_q;
                // Read happens before any same-edge write lands: no forwarding.
                cpu_rdata_d = lut_q[cpu_addr];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            busy_q      <= 1'b1;
            lvl_valid_q <= 1'b0;
            lvl_out_q   <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            q_q         <= q_d;
            r_q         <= r_d;
            busy_q      <= busy_d;
            lvl_valid_q <= lvl_valid_d;
            lvl_out_q   <= lvl_out_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    // Table storage is not reset; the init sweep rewrites every entry.
    always_ff @(posedge clk) begin
        if (!rst && lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end

    assign lvl_valid = lvl_valid_q;
    assign lvl_out   = lvl_out_q;
    assign cpu_rdata = cpu_rdata_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_video_level_expander.sv
module tb_video_level_expander;
    localparam int NCH = 3, IN_W = 5, OUT_W = 8, MAX_CODE = 24;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           mode;
    logic                 pix_valid, pix_blank;
    logic [NCH*IN_W-1:0]  pix_in;
    logic                 lvl_valid;
    logic [NCH*OUT_W-1:0] lvl_out;
    logic                 cpu_we;
    logic [IN_W-1:0]      cpu_addr;
    logic [OUT_W-1:0]     cpu_wdata, cpu_rdata;
    logic                 busy;

    int n_cmp = 0;
    int n_bad = 0;

    video_level_expander #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .MAX_CODE(MAX_CODE)) dut (
        .clk(clk), .rst(rst), .mode(mode), .pix_valid(pix_valid), .pix_blank(pix_blank),
        .pix_in(pix_in), .lvl_valid(lvl_valid), .lvl_out(lvl_out), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [1:0]      mode;
        logic            blank;
        logic [14:0]     pix;
        logic [23:0]     exp;
    } pix_vec_t;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    pix_vec_t pv [9];
    rd_vec_t  rv [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts edges until busy falls; bounded so a stuck FSM cannot hang the run.
    task automatic wait_busy_low(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic read_table(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cpu_addr = rv[i].addr;
            @(posedge clk); #1;
            chk($sformatf("%s_rd_addr%0d", tag, rv[i].addr), 32'(cpu_rdata), 32'(rv[i].exp));
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd1);
        chk({tag, "_lvl_valid"}, 32'(lvl_valid), 32'd0);
        chk({tag, "_lvl_out"},   32'(lvl_out),   32'd0);
        chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    endtask

    initial begin
        int n;

        pv[0] = '{"m0_lut",      2'd0, 1'b0, {5'd24, 5'd12, 5'd1},  24'hFF7F0A};
        pv[1] = '{"m0_lut_lo",   2'd0, 1'b0, {5'd0,  5'd3,  5'd2},  24'h001F15};
        pv[2] = '{"m1_rep_a",    2'd1, 1'b0, {5'd31, 5'd16, 5'd0},  24'hFF8400};
        pv[3] = '{"m1_rep_b",    2'd1, 1'b0, {5'd24, 5'd12, 5'd7},  24'hC66339};
        pv[4] = '{"m2_pad_a",    2'd2, 1'b0, {5'd31, 5'd16, 5'd1},  24'hF88008};
        pv[5] = '{"m2_pad_b",    2'd2, 1'b0, {5'd24, 5'd12, 5'd7},  24'hC06038};
        pv[6] = '{"m3_black",    2'd3, 1'b0, {5'd31, 5'd16, 5'd1},  24'h000000};
        pv[7] = '{"m1_blank",    2'd1, 1'b1, {5'd31, 5'd16, 5'd1},  24'h000000};
        pv[8] = '{"m0_blank",    2'd0, 1'b1, {5'd24, 5'd12, 5'd1},  24'h000000};

        rv[0] = '{5'd0,  8'd0};
        rv[1] = '{5'd1,  8'd10};
        rv[2] = '{5'd2,  8'd21};
        rv[3] = '{5'd3,  8'd31};
        rv[4] = '{5'd12, 8'd127};
        rv[5] = '{5'd24, 8'd255};
        rv[6] = '{5'd25, 8'd255};
        rv[7] = '{5'd31, 8'd255};

        rst = 1'b1; mode = 2'd0; pix_valid = 1'b0; pix_blank = 1'b0; pix_in = '0;
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst0");

        // Init sweep length and resulting table.
        @(negedge clk); rst = 1'b0;
        wait_busy_low(n);
        chk("init_cycles", 32'(n), 32'd32);
        read_table("init");

        // Pixel mode table.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            mode = pv[i].mode; pix_blank = pv[i].blank; pix_in = pv[i].pix; pix_valid = 1'b1;
            @(posedge clk); #1;
            chk({pv[i].name, "_vld"}, 32'(lvl_valid), 32'd1);
            chk({pv[i].name, "_out"}, 32'(lvl_out),   32'(pv[i].exp));
        end

        // Valid drop: strobe falls, levels hold.
        @(negedge clk);
        pix_valid = 1'b0; pix_blank = 1'b0; mode = 2'd1; pix_in = {5'd31, 5'd31, 5'd31};
        @(posedge clk); #1;
        chk("hold_vld", 32'(lvl_valid), 32'd0);
        chk("hold_out", 32'(lvl_out),   32'(pv[8].exp));
        @(negedge clk);
        mode = 2'd0; pix_valid = 1'b1; pix_in = {5'd24, 5'd12, 5'd1};
        @(negedge clk);
        pix_valid = 1'b0;
        @(posedge clk); #1;
        chk("hold2_vld", 32'(lvl_valid), 32'd0);
        chk("hold2_out", 32'(lvl_out),   32'h00FF7F0A);

        // Same-cycle LUT write and lookup of entry 5.
        @(negedge clk);
        mode = 2'd0; pix_valid = 1'b1; pix_in = {5'd0, 5'd0, 5'd5};
        cpu_we = 1'b1; cpu_addr = 5'd5; cpu_wdata = 8'hA5;
        @(posedge clk); #1;
        chk("wr_pix_old",  32'(lvl_out),   32'h00000035);
        chk("wr_rd_old",   32'(cpu_rdata), 32'h35);
        @(negedge clk);
        cpu_we = 1'b0;
        @(posedge clk); #1;
        chk("wr_pix_new",  32'(lvl_out),   32'h000000A5);
        chk("wr_rd_new",   32'(cpu_rdata), 32'hA5);

        // Mid-frame reset, then accesses during init are ignored.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_state("rst1");
        @(negedge clk);
        rst = 1'b0; pix_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd3; cpu_wdata = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("init_vld_%0d", i),   32'(lvl_valid), 32'd0);
            chk($sformatf("init_rdata_%0d", i), 32'(cpu_rdata), 32'd0);
        end
        @(negedge clk);
        pix_valid = 1'b0; cpu_we = 1'b0;
        wait_busy_low(n);
        chk("init2_cycles", 32'(n + 3), 32'd32);
        chk("init2_out", 32'(lvl_out), 32'd0);
        @(negedge clk); cpu_addr = 5'd3;
        @(posedge clk); #1;
        chk("init2_lut3", 32'(cpu_rdata), 32'd31);
        @(negedge clk); cpu_addr = 5'd5;
        @(posedge clk); #1;
        chk("init2_lut5", 32'(cpu_rdata), 32'd53);

        // Reset in the middle of the sweep restarts it from index 0.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midinit_busy", 32'(busy), 32'd1);
        @(negedge clk); rst = 1'b0;
        wait_busy_low(n);
        chk("midinit_cycles", 32'(n), 32'd32);
        read_table("midinit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/video_level_expander.md
Name: video_level_expander

Overview:
- Multi-channel colour-level expander between the pixel generator and the video DAC/HDMI encoder.
- Maps NCH channel codes of IN_W bits to OUT_W-bit levels through one of three modes:
  - a shared programmable LUT, which self-initialises to a full-scale linear table after reset;
  - bit-replicate;
  - zero-pad shift.
- The LUT is CPU-writable and readable through a simple register port.
- One-stage registered pipeline with a valid strobe.

Parameters:
- NCH, 3, number of colour channels sharing the LUT.
- IN_W, 5, input code width; LUT depth is 2**IN_W.
- OUT_W, 8, output level width; OUT_MAX = 2**OUT_W-1.
- MAX_CODE, 24, input code mapped to OUT_MAX by the init table; 1 <= MAX_CODE <= 2**IN_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- mode  in  2  0=LUT, 1=replicate, 2=zero-pad, 3=black.
- pix_valid  in  1  input pixel strobe.
- pix_blank  in  1  force all outputs to 0 for this pixel.
- pix_in  in  NCH*IN_W  channel codes; channel k is bits [k*IN_W +: IN_W].
- lvl_valid  out  1  output strobe.
- lvl_out  out  NCH*OUT_W  channel levels, same packing as pix_in.
- cpu_we  in  1  LUT write strobe.
- cpu_addr  in  IN_W  LUT entry index.
- cpu_wdata  in  OUT_W  LUT write data.
- cpu_rdata  out  OUT_W  LUT entry at cpu_addr, registered.
- busy  out  1  high while the init sequence runs.

Behaviour:
- Reset values, applied in the cycle rst is sampled high:
  - lvl_valid=0, lvl_out=0, cpu_rdata=0, busy=1.
  - FSM enters INIT with index=0, q=0, r=0.
  - LUT contents are not reset directly; INIT overwrites every entry.
- FSM:
  - INIT: each cycle writes LUT[index] = (index >= MAX_CODE) ? OUT_MAX : q, then advances the accumulator.
    - q += OUT_MAX / MAX_CODE (integer division); r += OUT_MAX % MAX_CODE.
    - If r >= MAX_CODE after the add: r -= MAX_CODE and q += 1.
    - Result: LUT[i] = floor(i*OUT_MAX/MAX_CODE), saturated at OUT_MAX.
    - After writing index 2**IN_W-1, go to RUN. INIT takes exactly 2**IN_W cycles after reset release.
  - RUN: normal operation. Leaves RUN only on rst.
- While busy=1:
  - cpu_we is ignored.
  - pix_valid is ignored; lvl_valid stays 0 and lvl_out stays 0.
  - cpu_rdata holds 0.
- Pixel path in RUN, latency 1 clock:
  - lvl_valid(t+1) = pix_valid(t).
  - lvl_out is updated only when pix_valid=1; it holds its value otherwise.
  - Per channel with code c:
    - mode 0: LUT[c]
    - mode 1: c replicated MSB-first to fill OUT_W bits (c=5'h1F gives 8'hFF; c=5'h10 gives 8'h84).
    - mode 2: {c, (OUT_W-IN_W) zeros}; if OUT_W <= IN_W, the top OUT_W bits of c.
    - mode 3: 0.
  - pix_blank=1 forces 0 on all channels regardless of mode.
  - mode and pix_blank are sampled in the same cycle as pix_in.
- CPU port in RUN:
  - cpu_we=1 writes LUT[cpu_addr] = cpu_wdata at the clock edge.
  - cpu_rdata(t+1) = LUT[cpu_addr(t)] as it was before any write at edge t; a write is not forwarded to readback.
  - Same-cycle write and pixel lookup of the same entry: the pixel gets the old value, and the new value is visible from the next lookup.
  - Writes and lookups never stall each other.
  - All NCH channels read the LUT concurrently (NCH read ports).
- rst asserted mid-frame or mid-INIT:
  - The pipeline and FSM reset as above.
  - INIT restarts from index 0.
- Arithmetic: q and r sized so that no value up to OUT_MAX+MAX_CODE overflows; no wrap at any index.

Test Plan:
- Release reset, then wait: busy=1 for exactly 32 cycles then 0. Read back cpu_addr 0,1,2,3,12,24,25,31 -> 0,10,21,31,127,255,255,255.
- mode=0, pix_valid=1, pix_in={ch2=24, ch1=12, ch0=1} -> next cycle lvl_valid=1, lvl_out={255,127,10}. Drop pix_valid -> lvl_valid=0, lvl_out holds.
- mode=1 with codes {31,16,0} -> {8'hFF,8'h84,8'h00}. mode=2 with codes {31,16,1} -> {8'hF8,8'h80,8'h08}. mode=3 -> all 0. pix_blank=1 in mode 0 -> all 0.
- Write LUT[5]=8'hA5 in the same cycle as a pixel with ch0=5 in mode 0 -> that pixel outputs 53. The next pixel with ch0=5 outputs 8'hA5. cpu_rdata for addr 5 issued in the write cycle returns 53, then 8'hA5 on re-read.
- During INIT: pulse pix_valid and cpu_we (addr 3, data 8'h00) -> lvl_valid stays 0 and, after INIT completes, LUT[3] reads back 31.
- Assert rst at INIT index 10 and release -> busy stays high a full 32 cycles from release, and the table matches the first scenario.
